// File: rtl/shift_tx_ctrl_pkg.sv
// Shared definitions for the serial transmit sequencer: state encoding, default
// geometry and the counter-width helper.
package shift_tx_ctrl_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefDiv   = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // One width serves both counters, so size it for the larger of the two ranges.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned div);
        int unsigned m;
        m = (width > div) ? width : div;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/shift_reg_en.sv
// Parallel-in/serial-out shift register; load has priority over shift, holds otherwise.
// Shifts right so bit 0 is the serial output.
module shift_reg_en #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/shift_tx_ctrl.sv
// Serial transmit sequencer: accepts a word on valid/ready, shifts it out LSB-first
// holding each bit DIV clocks, then pulses done for one cycle.
module shift_tx_ctrl
    import shift_tx_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DIV   = DefDiv
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH, DIV);
    localparam logic [CNT_W-1:0] DivLast = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BitLast = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             load, shift;
    logic             sr_bit;
    logic             sout_valid_q, busy_q, done_q;

    assign in_ready = (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    load      = 1'b1;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    // The last bit is not shifted away; DONE masks sout instead.
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
                        state_d   = StDone;
                    end else begin
                        shift     = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sout_valid_q <= (state_d == StShift);
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StDone);
        end
    end

    shift_reg_en #(
        .WIDTH(WIDTH)
    ) u_shift_reg (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift),
        .sin  (1'b0),
        .d    (in_data),
        .sout (sr_bit)
    );

    assign sout       = sout_valid_q & sr_bit;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl: a DIV=1 and a DIV=3 instance, serial bits checked
// against a scoreboard of expected bits pushed when each word is offered.
module tb_shift_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid1, in_valid3;
    logic [3:0] in_data1, in_data3;
    logic       in_ready1, sout1, sout_valid1, busy1, done1;
    logic       in_ready3, sout3, sout_valid3, busy3, done3;

    int checks = 0;
    int failures = 0;
    int done_cnt1 = 0;
    int done_cnt3 = 0;
    int exp_done1 = 0;
    logic q1[$];
    logic q3[$];

    always #5 clk = ~clk;

    shift_tx_ctrl #(.WIDTH(4), .DIV(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .sout      (sout1),
        .sout_valid(sout_valid1),
        .busy      (busy1),
        .done      (done1)
    );

    shift_tx_ctrl #(.WIDTH(4), .DIV(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .sout      (sout3),
        .sout_valid(sout_valid3),
        .busy      (busy3),
        .done      (done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every sout_valid cycle pops one expected bit.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (sout_valid1 === 1'b1) begin
                checks++;
                assert (q1.size() != 0) else begin
                    failures++;
                    $error("FAIL sb1_unexpected observed=%0h expected=none", sout1);
                end
                if (q1.size() != 0) chk("sb1_sout", {31'd0, sout1}, {31'd0, q1.pop_front()});
            end
            if (sout_valid3 === 1'b1) begin
                checks++;
                assert (q3.size() != 0) else begin
                    failures++;
                    $error("FAIL sb3_unexpected observed=%0h expected=none", sout3);
                end
                if (q3.size() != 0) chk("sb3_sout", {31'd0, sout3}, {31'd0, q3.pop_front()});
            end
            if (done1 === 1'b1) done_cnt1++;
            if (done3 === 1'b1) done_cnt3++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sends one word on dut1 and checks frame timing; junk cycles offer 4'hF while busy.
    task automatic xfer1(input logic [3:0] data, input int junk);
        in_valid1 = 1'b1;
        in_data1  = data;
        for (int i = 0; i < 4; i++) q1.push_back(data[i]);
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            in_valid1 = (c <= junk);
            in_data1  = (c <= junk) ? 4'hF : 4'h0;
            @(negedge clk);
            chk("xfer_shift_status", {28'd0, in_ready1, busy1, sout_valid1, done1}, 32'h6);
            next_cycle();
        end
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("xfer_done_status", {28'd0, in_ready1, busy1, sout_valid1, done1}, 32'h5);
        next_cycle();
        @(negedge clk);
        chk("xfer_ready_again", {28'd0, in_ready1, busy1, sout_valid1, done1}, 32'h8);
        exp_done1++;
        next_cycle();
    endtask

    initial begin
        int lows;
        int dones;
        logic [31:0] exp3;

        reset     = 1'b0;
        in_valid1 = 1'b1;
        in_data1  = 4'hF;
        in_valid3 = 1'b0;
        in_data3  = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dut1", {27'd0, in_ready1, busy1, sout_valid1, done1, sout1}, 32'h10);
        chk("reset_dut3", {27'd0, in_ready3, busy3, sout_valid3, done3, sout3}, 32'h10);
        in_valid1 = 1'b0;
        next_cycle();
        reset = 1'b1;

        // Idle with no valid offered.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_hold", {28'd0, in_ready1, busy1, sout_valid1, done1}, 32'h8);
        end
        next_cycle();

        // Basic word on DIV=1.
        xfer1(4'b1011, 0);

        // DIV=3: each bit held three cycles.
        in_valid3 = 1'b1;
        in_data3  = 4'b0110;
        for (int i = 0; i < 4; i++) repeat (3) q3.push_back(in_data3[i]);
        next_cycle();
        in_valid3 = 1'b0;
        in_data3  = 4'hF;
        for (int c = 1; c <= 14; c++) begin
            exp3 = (c <= 12) ? 32'h6 : (c == 13) ? 32'h5 : 32'h8;
            @(negedge clk);
            chk("div3_status", {28'd0, in_ready3, busy3, sout_valid3, done3}, exp3);
            next_cycle();
        end

        // Offers while busy are ignored.
        xfer1(4'h9, 2);

        // Reset during bit 2 of 4'hC aborts the word.
        in_valid1 = 1'b1;
        in_data1  = 4'hC;
        for (int i = 0; i < 3; i++) q1.push_back(in_data1[i]);
        next_cycle();
        in_valid1 = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_immediate", {27'd0, in_ready1, busy1, sout_valid1, done1, sout1}, 32'h10);
        next_cycle();
        @(negedge clk);
        chk("abort_held", {27'd0, in_ready1, busy1, sout_valid1, done1, sout1}, 32'h10);
        next_cycle();
        reset = 1'b1;
        chk("abort_no_done", done_cnt1, exp_done1);
        chk("abort_sb_drained", q1.size(), 0);
        xfer1(4'h6, 0);

        // Back-to-back words with in_valid held high.
        in_valid1 = 1'b1;
        in_data1  = 4'h5;
        for (int i = 0; i < 4; i++) q1.push_back(in_data1[i]);
        for (int i = 0; i < 4; i++) q1.push_back(i[0] ? 1'b1 : 1'b0);
        next_cycle();
        in_data1 = 4'hA;
        lows  = 0;
        dones = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 10 && sout_valid1 === 1'b0) lows++;
            if (done1 === 1'b1) dones++;
            next_cycle();
            if (c == 6) in_valid1 = 1'b0;
        end
        chk("b2b_gap_cycles", lows, 2);
        chk("b2b_done_pulses", dones, 2);
        exp_done1 += 2;
        repeat (2) next_cycle();

        chk("final_sb1_empty", q1.size(), 0);
        chk("final_sb3_empty", q3.size(), 0);
        chk("final_done_cnt1", done_cnt1, exp_done1);
        chk("final_done_cnt3", done_cnt3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
